// File: rtl/uart_tx_if.sv
// ============================================================================
//  Module   : uart_tx_if
//  Brief    : Send/Sent handshake, data byte and serial line of uart_tx.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_if;
    logic       Send;
    logic [7:0] Din;
    logic       Sout;
    logic       Sent;
    logic       busy;

    modport master (output Send, output Din, input Sout, input Sent, input busy);
    modport slave  (input Send, input Din, output Sout, output Sent, output busy);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module   : uart_tx
//  Brief    : 8-bit UART transmitter, start/8 data LSB first/parity/stop,
//             four-phase Send/Sent handshake, registered serial output.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx #(
    parameter int MAX_CYCLES_COUNT = 5208,
    parameter bit ODD_PARITY       = 1'b1
) (
    input  wire logic clk,
    input  wire logic Reset,
    uart_tx_if.slave  bus
);

    localparam logic [12:0] c_timer_max = 13'(MAX_CYCLES_COUNT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BITS  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [12:0] r_timer;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic        r_sout;
    logic        r_sent;
    logic        r_busy;
    logic        w_timer_done;
    logic        w_accept;
    logic        w_sout_next;
    logic        w_parity;

    assign w_timer_done = (r_timer == c_timer_max);
    assign w_parity     = ODD_PARITY ? ~^bus.Din : ^bus.Din;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the value Sout takes one edge later.
    always_comb begin
        w_state_next = r_state;
        w_sout_next  = 1'b1;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Send) begin
                    w_state_next = S_START;
                    w_accept     = 1'b1;
                end
            end
            S_START: begin
                w_sout_next = 1'b0;
                if (w_timer_done) w_state_next = S_BITS;
            end
            S_BITS: begin
                w_sout_next = r_shift[0];
                if (w_timer_done && (r_bit == 3'd7)) w_state_next = S_PAR;
            end
            S_PAR: begin
                w_sout_next = r_parity;
                if (w_timer_done) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_timer_done) w_state_next = S_ACK;
            end
            S_ACK: begin
                if (!bus.Send) w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_timer  <= 13'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_parity <= 1'b0;
            r_sout   <= 1'b1;
            r_sent   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || (r_state == S_ACK) || w_timer_done) begin
                r_timer <= 13'd0;
            end else begin
                r_timer <= r_timer + 13'd1;
            end

            if ((r_state == S_START) && w_timer_done) begin
                r_bit <= 3'd0;
            end else if ((r_state == S_BITS) && w_timer_done) begin
                r_bit <= r_bit + 3'd1;
            end

            // Parity is taken from the accepted byte since the shifter is consumed.
            if (w_accept) begin
                r_shift  <= bus.Din;
                r_parity <= w_parity;
            end else if ((r_state == S_BITS) && w_timer_done && (r_bit != 3'd7)) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end

            r_sout <= w_sout_next;
            r_sent <= (r_state == S_ACK);
            r_busy <= (r_state == S_START) || (r_state == S_BITS) ||
                      (r_state == S_PAR)   || (r_state == S_STOP);
        end
    end

    assign bus.Sout = r_sout;
    assign bus.Sent = r_sent;
    assign bus.busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module   : tb_uart_tx
//  Brief    : Self-checking bench for uart_tx; odd and even parity instances
//             driven in lockstep and compared against a frame-level model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int c_bit_cycles = 16;
    localparam int c_frame_cycles = 11 * c_bit_cycles;

    logic clk;
    logic Reset;
    int   tests_run;
    int   tests_failed;
    logic cur_send;
    logic [7:0] cur_din;

    uart_tx_if ifo ();
    uart_tx_if ife ();

    uart_tx #(.MAX_CYCLES_COUNT(15), .ODD_PARITY(1'b1)) dut_odd (
        .clk   (clk),
        .Reset (Reset),
        .bus   (ifo)
    );

    uart_tx #(.MAX_CYCLES_COUNT(15), .ODD_PARITY(1'b0)) dut_even (
        .clk   (clk),
        .Reset (Reset),
        .bus   (ife)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line bits in time order: bit 0 start, 1..8 data LSB first, 9 parity, 10 stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d, input bit odd);
        int  ones;
        logic p;
        ones = $countones(d);
        p = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic drive(input logic s, input logic [7:0] d);
        cur_send = s;
        cur_din  = d;
        ifo.Send = s;
        ife.Send = s;
        ifo.Din  = d;
        ife.Din  = d;
    endtask

    // Runs one accepted frame for 180 cycles and returns what was seen on the lines.
    task automatic run_frame(input logic [7:0] din, input bit keep_send, input bit disturb,
                             output logic [10:0] fo, output logic [10:0] fe,
                             output int sent_o, output int sent_e, output bit shape_ok);
        logic hold_o, hold_e;
        int   idx, ph;
        fo = '0; fe = '0; sent_o = 0; sent_e = 0; shape_ok = 1'b1;
        hold_o = 1'b1; hold_e = 1'b1;
        @(negedge clk);
        drive(1'b1, din);
        @(posedge clk);
        #1;
        if (!keep_send) drive(1'b0, din);
        for (int c = 1; c <= 180; c++) begin
            @(posedge clk);
            #1;
            if (disturb) begin
                if (c == 40) drive(cur_send, 8'hA3);
                if (c == 60) drive(1'b1, cur_din);
                if (c == 61) drive(1'b0, cur_din);
            end
            if (sent_o == 0 && ifo.Sent === 1'b1) sent_o = c;
            if (sent_e == 0 && ife.Sent === 1'b1) sent_e = c;
            if (c <= c_frame_cycles) begin
                idx = (c - 1) / c_bit_cycles;
                ph  = (c - 1) % c_bit_cycles;
                if (ph == 0) begin
                    hold_o = ifo.Sout;
                    hold_e = ife.Sout;
                end else if (ifo.Sout !== hold_o || ife.Sout !== hold_e) begin
                    shape_ok = 1'b0;
                end
                if (ph == 8) begin
                    fo[idx] = ifo.Sout;
                    fe[idx] = ife.Sout;
                end
            end else if (ifo.Sout !== 1'b1 || ife.Sout !== 1'b1) begin
                shape_ok = 1'b0;
            end
            if (ifo.busy !== (c <= c_frame_cycles) || ife.busy !== (c <= c_frame_cycles))
                shape_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        drive(1'b0, 8'h00);
        #2 Reset = 1'b1;
        #1;
        tests_run++;
        if ({ifo.Sout, ifo.Sent, ifo.busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_async_odd got Sout/Sent/busy=%b exp 100", {ifo.Sout, ifo.Sent, ifo.busy});
        end
        tests_run++;
        if ({ife.Sout, ife.Sent, ife.busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_async_even got Sout/Sent/busy=%b exp 100", {ife.Sout, ife.Sent, ife.busy});
        end
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({ifo.Sout, ifo.Sent, ifo.busy, ife.Sout, ife.Sent, ife.busy} !== 6'b100100) begin
            tests_failed++;
            $display("FAIL idle_after_reset got %b exp 100100",
                     {ifo.Sout, ifo.Sent, ifo.busy, ife.Sout, ife.Sent, ife.busy});
        end
    endtask

    task automatic test_frames();
        logic [7:0] bytes [6];
        logic [10:0] fo, fe;
        int so, se;
        bit ok;
        bytes[0] = 8'h55; bytes[1] = 8'h00; bytes[2] = 8'hFF;
        bytes[3] = 8'($urandom); bytes[4] = 8'($urandom); bytes[5] = 8'($urandom);
        foreach (bytes[i]) begin
            run_frame(bytes[i], 1'b0, 1'b0, fo, fe, so, se, ok);
            tests_run++;
            if (fo !== ref_frame(bytes[i], 1'b1)) begin
                tests_failed++;
                $display("FAIL frame_odd din=%h got %b exp %b", bytes[i], fo, ref_frame(bytes[i], 1'b1));
            end
            tests_run++;
            if (fe !== ref_frame(bytes[i], 1'b0)) begin
                tests_failed++;
                $display("FAIL frame_even din=%h got %b exp %b", bytes[i], fe, ref_frame(bytes[i], 1'b0));
            end
            tests_run++;
            if (so != c_frame_cycles + 1 || se != c_frame_cycles + 1) begin
                tests_failed++;
                $display("FAIL sent_latency din=%h got %0d/%0d exp %0d", bytes[i], so, se, c_frame_cycles + 1);
            end
            tests_run++;
            if (!ok || ifo.Sent !== 1'b0) begin
                tests_failed++;
                $display("FAIL frame_shape din=%h got shape=%0d Sent=%b exp shape=1 Sent=0", bytes[i], ok, ifo.Sent);
            end
        end
    endtask

    task automatic test_din_change();
        logic [10:0] fo, fe;
        int so, se;
        bit ok;
        run_frame(8'h3C, 1'b0, 1'b1, fo, fe, so, se, ok);
        tests_run++;
        if (fo !== ref_frame(8'h3C, 1'b1) || fe !== ref_frame(8'h3C, 1'b0)) begin
            tests_failed++;
            $display("FAIL din_change got %b/%b exp %b/%b", fo, fe, ref_frame(8'h3C, 1'b1), ref_frame(8'h3C, 1'b0));
        end
        tests_run++;
        if (!ok || so != c_frame_cycles + 1) begin
            tests_failed++;
            $display("FAIL din_change_shape got shape=%0d sent=%0d exp 1/%0d", ok, so, c_frame_cycles + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] fo, fe;
        int so, se;
        bit ok, ack_ok;
        logic [7:0] d1, d2;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        run_frame(d1, 1'b1, 1'b0, fo, fe, so, se, ok);
        tests_run++;
        if (fo !== ref_frame(d1, 1'b1) || fe !== ref_frame(d1, 1'b0) || !ok) begin
            tests_failed++;
            $display("FAIL held_send_frame din=%h got %b/%b shape=%0d", d1, fo, fe, ok);
        end
        ack_ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if ({ifo.Sent, ifo.busy, ifo.Sout, ife.Sent, ife.busy, ife.Sout} !== 6'b101101) ack_ok = 1'b0;
        end
        tests_run++;
        if (!ack_ok) begin
            tests_failed++;
            $display("FAIL ack_hold got second frame or Sent drop, exp Sent=1 busy=0 Sout=1");
        end
        @(negedge clk);
        drive(1'b0, d1);
        @(posedge clk);
        #1;
        run_frame(d2, 1'b0, 1'b0, fo, fe, so, se, ok);
        tests_run++;
        if (fo !== ref_frame(d2, 1'b1) || fe !== ref_frame(d2, 1'b0) || !ok) begin
            tests_failed++;
            $display("FAIL back_to_back din=%h got %b/%b shape=%0d exp %b/%b",
                     d2, fo, fe, ok, ref_frame(d2, 1'b1), ref_frame(d2, 1'b0));
        end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] fo, fe;
        int so, se;
        bit ok, quiet;
        @(negedge clk);
        drive(1'b1, 8'h5A);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h5A);
        repeat (87) @(posedge clk);
        #1;
        tests_run++;
        if (ifo.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midframe_busy got %b exp 1", ifo.busy);
        end
        #2 Reset = 1'b1;
        #1;
        tests_run++;
        if ({ifo.Sout, ifo.busy, ifo.Sent, ife.Sout, ife.busy, ife.Sent} !== 6'b100100) begin
            tests_failed++;
            $display("FAIL midframe_reset got %b exp 100100",
                     {ifo.Sout, ifo.busy, ifo.Sent, ife.Sout, ife.busy, ife.Sent});
        end
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        quiet = 1'b1;
        repeat (200) begin
            @(posedge clk);
            #1;
            if ({ifo.Sout, ifo.busy, ifo.Sent, ife.Sout, ife.busy, ife.Sent} !== 6'b100100) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL post_reset_quiet got activity without Send, exp idle line");
        end
        run_frame(8'h81, 1'b0, 1'b0, fo, fe, so, se, ok);
        tests_run++;
        if (fo !== ref_frame(8'h81, 1'b1) || fe !== ref_frame(8'h81, 1'b0) || !ok || so != c_frame_cycles + 1) begin
            tests_failed++;
            $display("FAIL frame_after_reset got %b/%b shape=%0d sent=%0d exp %b/%b",
                     fo, fe, ok, so, ref_frame(8'h81, 1'b1), ref_frame(8'h81, 1'b0));
        end
    endtask

    task automatic test_loopback();
        logic [7:0] perm [256];
        logic [7:0] tmp;
        logic [10:0] fo, fe;
        int so, se, j;
        bit ok;
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            run_frame(perm[i], 1'b0, 1'b0, fo, fe, so, se, ok);
            tests_run++;
            if (fo !== ref_frame(perm[i], 1'b1) || fe !== ref_frame(perm[i], 1'b0) ||
                !ok || so != c_frame_cycles + 1 || se != c_frame_cycles + 1) begin
                tests_failed++;
                $display("FAIL loopback din=%h got %b/%b shape=%0d sent=%0d/%0d exp %b/%b",
                         perm[i], fo, fe, ok, so, se, ref_frame(perm[i], 1'b1), ref_frame(perm[i], 1'b0));
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_frames();
        test_din_change();
        test_back_to_back();
        test_reset_midframe();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter MAX_CYCLES_COUNT, default 5208: last count value of the baud timer; one bit time = MAX_CYCLES_COUNT+1 clk cycles.
REQ-002 Parameter ODD_PARITY, default 1: 1 = odd parity, 0 = even parity.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Send  input  1  request to transmit Din; level-sensitive, part of the four-phase handshake with Sent.
REQ-006 Din  input  8  byte to transmit; sampled only on the accepting edge.
REQ-007 Sout  output  1  serial line; idle high; driven from a flop.
REQ-008 Sent  output  1  frame complete; high in ACK state only.
REQ-009 busy  output  1  high while a frame is on the line (START, BITS, PAR, STOP).

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1): 11 bit times = 11*(MAX_CYCLES_COUNT+1) cycles.
REQ-011 Parity bit SHALL be ~^Din_latched when ODD_PARITY=1 and ^Din_latched when ODD_PARITY=0, so the data plus parity 1-count is odd or even respectively.
REQ-012 Baud timer SHALL be a 13-bit counter; it clears in IDLE and ACK, increments otherwise, and wraps to 0 on reaching MAX_CYCLES_COUNT (timerDone).
REQ-013 Bit counter SHALL be 3-bit, cleared on entry to BITS, and incremented on each timerDone in BITS; bit 7 with timerDone exits BITS.
REQ-014 FSM states SHALL be IDLE, START, BITS, PAR, STOP, ACK.
REQ-015 IDLE: Sout=1; Send=1 at a posedge -> latch Din into the shift register, go to START.
REQ-016 START: Sout=0; timerDone -> BITS.
REQ-017 BITS: Sout=shift_reg[0]; timerDone and bit<7 -> shift right, bit+1; timerDone and bit==7 -> PAR.
REQ-018 PAR: Sout=parity bit; timerDone -> STOP.
REQ-019 STOP: Sout=1; timerDone -> ACK.
REQ-020 ACK: Sout=1, Sent=1; Send=0 -> IDLE; Send still 1 -> stay in ACK, with no second frame started.
REQ-021 Sout SHALL change exactly one cycle after the state/bit transition that selects it (registered), with glitch-free bit boundaries.
REQ-022 Latency SHALL be: Send high at edge N -> Sout=0 from edge N+1; Sent high from edge N+1+11*(MAX_CYCLES_COUNT+1).
REQ-023 Din changes and Send toggles while busy SHALL be ignored; the transmitted byte is the value latched at acceptance.
REQ-024 Back-to-back: the earliest the next frame starts is the edge after Send is observed low in ACK then high in IDLE (minimum 2 idle cycles of Sout=1 plus any ACK time).
REQ-025 Undefined state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-026 Reset asserted SHALL immediately, without waiting for clk, force: state=IDLE, Sout=1, Sent=0, busy=0, timer=0, bit counter=0, shift register=0.
REQ-027 Reset mid-frame SHALL abort the frame with Sout high at once; no Sent pulse for the aborted byte; the first frame after release starts only on a new Send.
REQ-028 After Reset deasserts, the block SHALL behave as from IDLE on the first posedge clk.

Verification (MAX_CYCLES_COUNT=15 for the bench, 16 cycles per bit)
REQ-029 Din=0x55, ODD_PARITY=1, Send pulse -> Sout 0,1,0,1,0,1,0,1,0, parity 1, stop 1, each 16 cycles; Sent high at cycle 177 after acceptance.
REQ-030 Din=0x00 -> parity bit 1 (odd); same byte with ODD_PARITY=0 -> parity bit 0; Din=0xFF, ODD_PARITY=1 -> parity bit 1.
REQ-031 Send held high throughout -> exactly one frame; Sent stays 1 in ACK until Send drops, then IDLE with Sout=1.
REQ-032 Din changed to 0xA3 during the BITS state of a 0x3C frame -> the serialized data still reads 0x3C.
REQ-033 Reset pulsed (asynchronous, between clk edges) during bit 4 -> Sout=1 and busy=0 before the next edge; no Sent; a new 0x81 frame afterwards is correct.
REQ-034 Loopback into the matching receiver, 256 bytes, both parity modes -> every Dout equals Din with error=0.
